// File: rtl/param_shuffler_if.sv
// Two-lane sample bus for the delay commutator: input beat side plus registered output side.
interface param_shuffler_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              frame_start;
  logic              bypass;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic              out_valid;

  modport master (
    output in_valid, frame_start, bypass, a, b,
    input  a1, b1, out_valid
  );

  modport slave (
    input  in_valid, frame_start, bypass, a, b,
    output a1, b1, out_valid
  );
endinterface

// File: rtl/param_shuffler.sv
// Delay commutator for the pipelined FFT: pairs samples DEPTH beats apart across two lanes,
// with an internal phase counter, valid-gated stalls, frame resync and an aligned bypass mode.
module param_shuffler #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 9,
  parameter int CNT_W  = $clog2(2*DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  param_shuffler_if.slave  bus
);

  localparam int FILL_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(2*DEPTH-1);
  localparam logic [FILL_W-1:0] FULL_C = FILL_W'(DEPTH);

  logic [CNT_W-1:0]  phase_reg;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  phase_next;
  logic [FILL_W-1:0] fill_reg;
  logic              swap;

  logic [DATA_W-1:0] aline_reg [DEPTH];
  logic [DATA_W-1:0] bline_reg [DEPTH];
  logic [DATA_W-1:0] bd;
  logic [DATA_W-1:0] y0;
  logic [DATA_W-1:0] y1;
  logic [DATA_W-1:0] y0d;

  logic [DATA_W-1:0] a1_reg;
  logic [DATA_W-1:0] b1_reg;
  logic              out_valid_reg;

  // frame_start overrides the running phase for this beat only; phase then continues from cnt.
  always_comb begin
    cnt        = bus.frame_start ? '0 : phase_reg;
    phase_next = (cnt == LAST_C) ? '0 : cnt + CNT_W'(1);
    swap       = (cnt >= HALF_C) && !bus.bypass;
    bd         = bline_reg[DEPTH-1];
    y0d        = aline_reg[DEPTH-1];
    y0         = swap ? bd : bus.a;
    y1         = swap ? bus.a : bd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg     <= '0;
      fill_reg      <= '0;
      a1_reg        <= '0;
      b1_reg        <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid && (fill_reg == FULL_C);
      if (bus.in_valid) begin
        a1_reg    <= y0d;
        b1_reg    <= y1;
        phase_reg <= phase_next;
        if (fill_reg != FULL_C) begin
          fill_reg <= fill_reg + FILL_W'(1);
        end
      end
    end
  end

  // Lane 0 delays the commutated sample so both lanes leave with the same D-beat alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        aline_reg[i] <= '0;
        bline_reg[i] <= '0;
      end
    end else if (bus.in_valid) begin
      aline_reg[0] <= y0;
      bline_reg[0] <= bus.b;
      for (int i = 1; i < DEPTH; i++) begin
        aline_reg[i] <= aline_reg[i-1];
        bline_reg[i] <= bline_reg[i-1];
      end
    end
  end

  assign bus.a1        = a1_reg;
  assign bus.b1        = b1_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: doc/param_shuffler.md
# param_shuffler

Parametrised delay-commutator (data shuffler) for the pipelined FFT datapath. It sits between butterfly stages and reorders two parallel complex-sample lanes so that samples DEPTH apart are brought together. Compared with the fixed-width, externally-switched basic shuffler, it adds:
- generic sample width and delay depth;
- an internal phase counter that generates the swap control;
- valid-gated stall tolerance;
- frame resynchronisation;
- a bypass mode that keeps both lanes aligned.

## Interface
Parameters:
- DATA_W, default 32: width of one complex sample (real in upper half, imag in lower half; treated as opaque bits).
- DEPTH, default 9: commutator delay D in accepted beats. Must be at least 1; any integer is legal, not only powers of two.
- CNT_W, default $clog2(2*DEPTH): width of the phase counter. Derived; do not override.

Ports (clock and reset first):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: a and b carry a beat this cycle. All internal state advances only when in_valid=1.
- frame_start, input, 1: qualified by in_valid. Forces the phase of the current beat to 0.
- bypass, input, 1: when 1, forces swap=0 for the current beat.
- a, input, DATA_W: lane-0 input sample.
- b, input, DATA_W: lane-1 input sample.
- a1, output, DATA_W: lane-0 output, registered.
- b1, output, DATA_W: lane-1 output, registered.
- out_valid, output, 1: a1/b1 hold a valid beat this cycle.

## Operation
Definitions for accepted beat k (a cycle with in_valid=1):
- cnt = frame_start ? 0 : phase. phase is a counter that runs 0..2D-1 and wraps.
- After the beat, phase ← cnt+1, or 0 if cnt = 2D-1.
- bd = b from beat k-D, taken from the lane-1 delay line. The line is DEPTH words and shifts only on accepted beats.
- swap = (cnt >= D) && !bypass.
- y0 = swap ? bd : a.
- y1 = swap ? a : bd.
- y0 enters the lane-0 delay line (DEPTH words, shifts on accepted beats). y0d = y0 from beat k-D.
- Registered update on beat k: a1 ← y0d, b1 ← y1.

Fill and valid:
- fill is a counter saturating at D; it increments on each accepted beat while fill < D.
- out_valid ← in_valid && (fill == D), evaluated before this beat's increment.
- The first D accepted beats after reset produce no valid output.

Mode and sync behaviour:
- Bypass gives a1 = a delayed D and b1 = b delayed D, so lane alignment is identical to swap mode.
- bypass may toggle on any beat and takes effect on that beat.
- frame_start does not clear the delay lines or fill. It only realigns phase.
- frame_start while in_valid=0 is ignored.

Implementation: the delay lines may be shift registers or circular RAM buffers with shared read/write pointers. The behaviour must be identical either way.

## Timing
- Reset (async assert, rst_n=0) sets:
  - a1=0, b1=0, out_valid=0;
  - phase=0, fill=0;
  - all delay-line words to 0.
- Reset deassertion is synchronous to clk by the upstream reset synchroniser.
- Latency: the outputs for beat k appear the cycle after beat k is accepted.
  - b1 carries a from beat k (swap half) or b from beat k-D.
  - a1 carries data from beats k-D or k-2D.
- Stall (in_valid=0):
  - a1, b1, phase, fill and both delay lines hold their values;
  - out_valid=0 the following cycle.
- Back-to-back beats give one output per cycle, with no bubbles.
- Reset mid-frame discards all buffered data. The next valid output occurs D accepted beats after release.
- DEPTH=1: the period is 2, and swap alternates on every beat.

## Test plan
All scenarios use DATA_W=8 and DEPTH=2, with a=0x10+k and b=0x20+k on beat k.
- **Reset/fill:**
  - Stimulus: hold rst_n=0, then stream continuous beats from k=0.
  - Required: outputs are 0 during reset; out_valid=0 after beats 0 and 1, and first goes 1 after beat 2.
- **Commutation:**
  - Stimulus: continuous stream from phase 0.
  - Required: (a1,b1) after beats 2..7 are (10,12), (11,13), (20,22), (21,23), (14,16), (15,17).
- **Stall:**
  - Stimulus: same stream with in_valid=0 for 3 cycles after beat 3.
  - Required: a1/b1 hold (11,13); out_valid=0 for 3 cycles; the sequence then resumes with (20,22), unchanged.
- **Bypass:**
  - Stimulus: bypass=1 throughout.
  - Required: the output after beat k≥2 is (0x10+k-2, 0x20+k-2).
- **Resync:**
  - Stimulus: assert frame_start on beat 5 (phase would be 1).
  - Required: beat 5 uses cnt=0 (no swap), and beats 7 and 8 swap.
- **Async reset:**
  - Stimulus: pulse rst_n low mid-cycle during beat 4.
  - Required: outputs clear immediately, not at the next edge; refill behaves as in the reset/fill scenario.
